// File: rtl/sort_frame_packer.sv
// Packs a serial 2-bit element stream into 4-slot frame words for the odd-even sorter,
// and carries each frame's {vld, id, pad} sideband through a delay line matched to the sorter.
module sort_frame_packer #(
  parameter int                ELEM_W   = 2,
  parameter int                N_ELEM   = 4,
  parameter int                SORT_LAT = 3,
  parameter int                ID_W     = 4,
  parameter logic [ELEM_W-1:0] PAD_VAL  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ELEM_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_ELEM*ELEM_W-1:0] sort_in,
  output logic                     sort_in_vld,
  output logic                     res_vld,
  output logic [ID_W-1:0]          res_id,
  output logic [2:0]               res_pad,
  output logic [ID_W-1:0]          frame_cnt
);

  localparam int FRAME_W = N_ELEM * ELEM_W;
  localparam int SB_W    = 1 + ID_W + 3;

  typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} state_t;

  state_t             state_reg;
  logic [1:0]         fill;
  logic [FRAME_W-1:0] buf_reg;
  logic [FRAME_W-1:0] frame_next;
  logic [ID_W-1:0]    sort_id_reg;
  logic [2:0]         sort_pad_reg;
  logic               accept;
  logic               emit;

  assign fill   = state_reg;
  assign accept = s_valid && s_ready;
  assign emit   = accept && (state_reg == FILL3 || s_last);

  // Candidate frame: buffered slots below the fill point, the new element at it, padding above.
  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_slot
      assign frame_next[gi*ELEM_W +: ELEM_W] =
        (gi == int'(fill)) ? s_data :
        (gi >  int'(fill)) ? PAD_VAL :
                             buf_reg[gi*ELEM_W +: ELEM_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= FILL0;
      buf_reg      <= '0;
      s_ready      <= 1'b0;
      sort_in      <= '0;
      sort_in_vld  <= 1'b0;
      sort_id_reg  <= '0;
      sort_pad_reg <= '0;
      frame_cnt    <= '0;
    end else begin
      s_ready     <= 1'b1;
      sort_in_vld <= emit;
      if (accept) begin
        buf_reg <= frame_next;
        if (emit) begin
          state_reg    <= FILL0;
          sort_in      <= frame_next;
          sort_id_reg  <= frame_cnt;
          sort_pad_reg <= 3'(N_ELEM - 1) - 3'(fill);
          frame_cnt    <= frame_cnt + ID_W'(1);
        end else begin
          state_reg <= state_t'(fill + 2'd1);
        end
      end
    end
  end

  // Sideband enters alongside sort_in, so its tail lines up with the sorter's registered output.
  logic [SB_W-1:0] dly_reg [SORT_LAT];
  logic [SB_W-1:0] dly_in  [SORT_LAT];

  generate
    for (gi = 0; gi < SORT_LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        assign dly_in[gi] = {sort_in_vld, sort_id_reg, sort_pad_reg};
      end else begin : g_tail
        assign dly_in[gi] = dly_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SORT_LAT; i++) dly_reg[i] <= '0;
    end else begin
      for (int i = 0; i < SORT_LAT; i++) dly_reg[i] <= dly_in[i];
    end
  end

  assign {res_vld, res_id, res_pad} = dly_reg[SORT_LAT-1];

endmodule

// File: tb/tb_sort_frame_packer.sv
// Scoreboard bench for sort_frame_packer: a driver feeds elements and a frame-level model,
// while a negedge monitor checks frame pulses and latency-aligned result sideband.
module tb_sort_frame_packer;
  localparam int SORT_LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_data;
  logic       s_last;
  logic [7:0] sort_in;
  logic       sort_in_vld;
  logic       res_vld;
  logic [3:0] res_id;
  logic [2:0] res_pad;
  logic [3:0] frame_cnt;

  always #5 clk = ~clk;

  sort_frame_packer dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .sort_in(sort_in), .sort_in_vld(sort_in_vld),
    .res_vld(res_vld), .res_id(res_id), .res_pad(res_pad),
    .frame_cnt(frame_cnt)
  );

  typedef struct { logic [7:0] word; int id; int pad; int cyc; } frame_t;
  typedef struct { int id; int pad; int due; } res_t;

  frame_t frame_q[$];
  res_t   res_q[$];
  int     cur[$];
  int     next_id = 0;
  int     cyc     = 0;
  int     checks  = 0;
  int     passes  = 0;
  int     pulses  = 0;
  logic   rst_q   = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  // Frame-level reference: element i of a frame is worth value * 4^i; missing slots are zero.
  task automatic model_accept(input logic [1:0] d, input logic last);
    frame_t f;
    int w;
    cur.push_back(int'(d));
    if (last || cur.size() == 4) begin
      w = 0;
      foreach (cur[i]) w += cur[i] * (1 << (2 * i));
      f.word = 8'(w);
      f.id   = next_id;
      f.pad  = 4 - cur.size();
      f.cyc  = cyc;
      frame_q.push_back(f);
      $display("frame id=%0d word=%02h pad=%0d expected at cycle %0d", f.id, f.word, f.pad, f.cyc);
      next_id = (next_id + 1) % 16;
      cur.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] d, input logic last);
    logic acc;
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) check("accept_timeout", 32'(s_ready), 32'd1);
    else model_accept(d, last);
    s_valid = 1'b0;
    s_data  = 2'($urandom);
    s_last  = 1'($urandom);
  endtask

  always @(negedge clk) begin
    frame_t f;
    res_t   r;
    if (!rst_q) begin
      check("reset_outputs",
            32'({sort_in, sort_in_vld, res_vld, res_id, res_pad, frame_cnt, s_ready}), 32'd0);
    end else begin
      check("s_ready", 32'(s_ready), 32'd1);
      if (sort_in_vld) begin
        pulses++;
        if (frame_q.size() == 0) begin
          check("spurious_frame", 32'(sort_in_vld), 32'd0);
        end else begin
          f = frame_q.pop_front();
          check("frame_word", 32'(sort_in), 32'(f.word));
          check("frame_cycle", cyc, f.cyc);
          check("frame_cnt_after", 32'(frame_cnt), 32'((f.id + 1) % 16));
          r.id  = f.id;
          r.pad = f.pad;
          r.due = cyc + SORT_LAT;
          res_q.push_back(r);
        end
      end else if (frame_q.size() != 0 && frame_q[0].cyc <= cyc) begin
        check("missing_frame", 32'(sort_in_vld), 32'd1);
        void'(frame_q.pop_front());
      end
      if (res_vld) begin
        if (res_q.size() == 0) begin
          check("spurious_res", 32'(res_vld), 32'd0);
        end else begin
          r = res_q.pop_front();
          $display("result id=%0d pad=%0d at cycle %0d", res_id, res_pad, cyc);
          check("res_id", 32'(res_id), 32'(r.id));
          check("res_pad", 32'(res_pad), 32'(r.pad));
          check("res_cycle", cyc, r.due);
        end
      end else if (res_q.size() != 0 && res_q[0].due <= cyc) begin
        check("missing_res", 32'(res_vld), 32'd1);
        void'(res_q.pop_front());
      end
    end
  end

  initial begin
    int p0;
    int n;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 2'd0;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);

    // Full frame 3,1,2,0.
    send(2'd3, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd0, 1'b0);
    check("full_word", 32'(sort_in), 32'h27);
    check("full_vld", 32'(sort_in_vld), 32'd1);
    idle(6);
    check("held_vld_low", 32'(sort_in_vld), 32'd0);
    check("held_word", 32'(sort_in), 32'h27);

    // Short frame 2,3(last).
    check("cnt_before_short", 32'(frame_cnt), 32'(next_id));
    send(2'd2, 1'b0); send(2'd3, 1'b1);
    check("short_word", 32'(sort_in), 32'h0E);
    check("cnt_after_short", 32'(frame_cnt), 32'(next_id));
    idle(6);

    // Eight elements with gaps between them.
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      send(2'($urandom), 1'b0);
      idle(1);
    end
    idle(5);
    check("gap_pulses", 32'(pulses - p0), 32'd2);

    // Seventeen full frames exercise the ID wrap.
    for (int i = 0; i < 17 * 4; i++) send(2'($urandom), 1'b0);
    idle(1);
    check("cnt_after_wrap", 32'(frame_cnt), 32'(next_id));

    // Random lengths and gaps, including back-to-back single-element frames.
    for (int i = 0; i < 120; i++) begin
      send(2'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    for (int i = 0; i < 6; i++) send(2'($urandom), 1'b1);
    send(2'($urandom), 1'b1);
    idle(6);

    // Reset one cycle before a result is due, with a partial frame buffered.
    send(2'd1, 1'b0);
    send(2'd2, 1'b1);
    send(2'd3, 1'b0);
    idle(1);
    rst_n = 1'b0;
    frame_q.delete();
    res_q.delete();
    cur.delete();
    next_id = 0;
    idle(1);
    rst_n = 1'b1;
    send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0);
    check("post_reset_word", 32'(sort_in), 32'hE4);
    check("post_reset_cnt", 32'(frame_cnt), 32'd1);

    n = 0;
    while ((res_q.size() != 0 || frame_q.size() != 0) && n < 30) begin
      idle(1);
      n++;
    end
    idle(4);
    check("drain", 32'(res_q.size() + frame_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sort_frame_packer.md
Name: sort_frame_packer

Overview:
- Upstream feeder for the 4-element, 2-bit, 3-stage pipelined odd-even sorter.
- Accepts a serial stream of 2-bit elements on a valid/ready interface and packs every 4 elements into one 8-bit frame word. A frame may also close early on s_last, with the unfilled slots padded.
- Presents each frame word to the sorter for exactly one cycle.
- Carries a sideband (valid, frame ID, pad count) through a delay line matched to the sorter latency, so downstream logic can tell which sorter output cycles hold real results.

Parameters:
- ELEM_W, 2, bits per element.
- N_ELEM, 4, elements per frame. Fixed at 4 for the current sorter.
- SORT_LAT, 3, sorter latency in clock edges from its input to its registered output.
- ID_W, 4, width of the frame ID counter (wraps).
- PAD_VAL, 0, value written into unfilled slots of a short frame.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  1  element valid.
- s_ready  out  1  packer can accept an element.
- s_data  in  ELEM_W  element value.
- s_last  in  1  close the current frame after this element; qualified by s_valid && s_ready.
- sort_in  out  N_ELEM*ELEM_W  packed frame word to the sorter input.
- sort_in_vld  out  1  one-cycle strobe: sort_in holds a new frame.
- res_vld  out  1  sorter output in this cycle is a valid frame result.
- res_id  out  ID_W  frame ID of the result qualified by res_vld.
- res_pad  out  3  number of padded slots in that result (0..N_ELEM-1).
- frame_cnt  out  ID_W  ID to be assigned to the next emitted frame.

Behaviour:
- Reset (rst_n low at posedge) drives all registered state to zero:
  - outputs: sort_in=0, sort_in_vld=0, res_vld=0, res_id=0, res_pad=0, frame_cnt=0, s_ready=0;
  - internal: fill count, partial-frame buffer and the entire delay line.
- s_ready is registered. It goes to 1 on the first edge with rst_n high and stays 1. The sorter never stalls, so there is no backpressure after reset.
- Handshake: an element is accepted on a posedge with s_valid && s_ready. s_data and s_last are ignored otherwise.
- State machine:
  - FILL(k), k=0..3, where k is the number of elements buffered; reset state is FILL(0).
  - An accept in FILL(k) writes s_data to slot k, i.e. bits [k*ELEM_W +: ELEM_W]. Slot 0 is the first element of the frame.
  - Emit condition: k==3, or s_last set. On emit:
    - at the same edge, load sort_in with the buffered slots plus the new element, with slots above k set to PAD_VAL;
    - sort_in_vld=1 for that one cycle;
    - pad count = 3-k;
    - frame ID = frame_cnt;
    - frame_cnt increments, wrapping modulo 2^ID_W;
    - return to FILL(0).
  - Otherwise: go to FILL(k+1), and sort_in_vld=0.
- Between frames sort_in holds its last value and sort_in_vld=0.
- Latency:
  - the last element of a frame accepted at edge E gives sort_in/sort_in_vld valid in the cycle after E;
  - the sorter registers the result at edge E+SORT_LAT;
  - res_vld/res_id/res_pad are asserted in the same cycle as that sorter output.
- Delay line: a SORT_LAT-deep shift register of {vld, id, pad}, fed from {sort_in_vld, emitted ID, pad count}. It shifts every cycle and is cleared on reset.
- Back-to-back frames are allowed. A new frame can emit every 4th cycle, or every cycle when s_last is set on every element. Each emission is tracked independently.
- s_last at FILL(0): a 1-element frame, res_pad=3.
- s_valid low for any number of cycles: the partial frame is retained indefinitely, with no timeout.
- Reset mid-fill or mid-flight: the partial frame is discarded and no res_vld is produced for in-flight frames. This matches the sorter pipeline registers clearing to 0.
- frame_cnt wraps from 2^ID_W-1 to 0 with no flag.

Test Plan:
- Reset release: hold rst_n=0 for 3 cycles, then release → all outputs 0 during reset; s_ready=1 from the first cycle after release; res_vld never asserts with no input.
- Full frame: send elements 3,1,2,0 on consecutive cycles, s_last=0 → one sort_in_vld pulse with sort_in=8'h27, id 0. res_vld=1 exactly 3 cycles after that pulse with res_id=0, res_pad=0; sorter output then reads 8'h1B, assuming highest-in-slot-0 ordering.
- Short frame: send 2, then 3 with s_last=1 → sort_in=8'h0E, res_pad=2, frame_cnt 0→1.
- Streaming and gaps: send 8 elements with s_valid toggling 1,0,1,... → exactly 2 sort_in_vld pulses; res_id 0 then 1; each res_vld exactly SORT_LAT cycles after its pulse; no lost or duplicated element.
- ID wrap: send 17 full frames → res_id sequence 0..15,0; frame_cnt=1 at the end.
- Reset mid-operation: accept 2 elements, emit one frame, pulse rst_n low 1 cycle before its res_vld is due → no res_vld for that frame; the next 4 elements form a frame with id 0 and contain none of the pre-reset elements.
